multicycle_datapath: RTL and testbench

//  Parametrised multi-cycle RV32I-subset core: fetch/decode/execute/mem/writeback FSM over a

---
 rtl/multicycle_datapath.sv | 177 +++++++++++++++++
 tb/tb_multicycle_datapath.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ==== multicycle_datapath (rev 1.0) =======================================================
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with handshaked imem/dmem.
module multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            retire,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);
  localparam int         AW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state, state_nxt;

  logic [31:0]     ir;
  logic [XLEN-1:0] pc, a, b, imm, alu_out, mdr;
  logic [XLEN-1:0] regs [NREGS];
  logic            illegal_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [AW-1:0]   rs1, rs2, rd;
  logic            op_ok, br_taken;
  logic [XLEN-1:0] imm_dec, op2, alu_res, pc_next, br_target;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[7 +: AW];
  assign rs1    = ir[15 +: AW];
  assign rs2    = ir[20 +: AW];

  // Only the listed subset is legal; anything else (including ecall) leaves DECODE for HALT.
  always_comb begin
    op_ok = 1'b0;
    case (opcode)
      OP_R:  op_ok = (funct7 == 7'b0000000 && funct3 != 3'b011) ||
                     (funct7 == 7'b0100000 && funct3 == 3'b000);
      OP_I:  op_ok = (funct3 != 3'b001) && (funct3 != 3'b011) && (funct3 != 3'b101);
      OP_LW: op_ok = (funct3 == 3'b010);
      OP_SW: op_ok = (funct3 == 3'b010);
      OP_BR: op_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
      default: op_ok = 1'b0;
    endcase
  end

  // Branch imm holds offset[12:1]; EXEC shifts it back by one.
  always_comb begin
    case (opcode)
      OP_SW:   imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:   imm_dec = {{(XLEN-12){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8]};
      default: imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    op2     = (opcode == OP_R) ? b : imm;
    alu_res = a + op2;
    case (funct3)
      3'b000:  alu_res = (opcode == OP_R && funct7[5]) ? (a - op2) : (a + op2);
      3'b001:  alu_res = a << op2[4:0];
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(op2))};
      3'b100:  alu_res = a ^ op2;
      3'b101:  alu_res = a >> op2[4:0];
      3'b110:  alu_res = a | op2;
      3'b111:  alu_res = a & op2;
      default: alu_res = a + op2;
    endcase
  end

  assign pc_next   = pc + XLEN'(4);
  assign br_target = pc + (imm << 1);
  assign br_taken  = funct3[0] ? (a != b) : (a == b);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (imem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = op_ok ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (opcode == OP_BR)                         state_nxt = S_FETCH;
        else if (opcode == OP_LW || opcode == OP_SW) state_nxt = S_MEM;
        else                                         state_nxt = S_WB;
      end
      S_MEM:    if (dmem_ready) state_nxt = (opcode == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= PC_RESET;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      imm       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          a   <= regs[rs1];
          b   <= regs[rs2];
          imm <= imm_dec;
          if (!op_ok && opcode != OP_SYS) illegal_q <= 1'b1;
        end
        S_EXEC: begin
          if (opcode == OP_BR)                         pc      <= br_taken ? br_target : pc_next;
          else if (opcode == OP_LW || opcode == OP_SW) alu_out <= a + imm;
          else                                         alu_out <= alu_res;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (opcode == OP_SW) pc  <= pc_next;
            else                 mdr <= dmem_rdata;
          end
        end
        S_WB:    pc <= pc_next;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == S_WB && rd != '0) begin
      regs[rd] <= (opcode == OP_LW) ? mdr : alu_out;
    end
  end

  // Requests are gated by reset so an in-flight handshake drops the moment reset asserts.
  assign imem_req   = reset && (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = reset && (state == S_MEM);
  assign dmem_we    = dmem_req && (opcode == OP_SW);
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b;
  assign retire     = (state == S_WB) ||
                      (state == S_EXEC && opcode == OP_BR) ||
                      (state == S_MEM && dmem_ready && opcode == OP_SW);
  assign halted     = (state == S_HALT);
  assign illegal    = illegal_q;
  assign pc_out     = pc;
  assign dbg_data   = regs[dbg_sel[AW-1:0]];
endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ==== tb_multicycle_datapath (rev 1.0) ====================================================
// Directed programs against imem/dmem models; retire and dmem traffic checked from scoreboards.
module tb_multicycle_datapath;
  localparam logic [6:0]  OP_I  = 7'b0010011;
  localparam logic [6:0]  OP_LW = 7'b0000011;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        retire, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out, dbg_data;
  logic [4:0]  dbg_sel;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int imem_wait, dmem_wait, icnt, dcnt, cyc;
  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] pc; int lat; } ret_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dm_t;
  ret_t sq[$];
  dm_t  dq[$];
  ret_t rm;
  dm_t  dd;

  multicycle_datapath #(.XLEN(32), .NREGS(32), .PC_RESET(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .retire(retire), .halted(halted), .illegal(illegal), .pc_out(pc_out),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    enc_r = {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    enc_i = {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    enc_s = {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    logic [12:0] o;
    o = 13'(off);
    enc_b = {o[12], o[10:5], 5'(rs2), 5'(rs1), f3, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic exp_ret(input logic [31:0] pc, input int lat);
    sq.push_back('{pc: pc, lat: lat});
  endtask

  task automatic exp_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dq.push_back('{we: we, addr: addr, wdata: wdata});
  endtask

  // Instruction memory: ready after imem_wait idle cycles of an outstanding request.
  always begin
    @(negedge clock); #1;
    if (!reset || !imem_req) begin
      imem_ready = 1'b0;
      icnt       = 0;
    end else if (icnt >= imem_wait) begin
      imem_ready = 1'b1;
      imem_rdata = imem[imem_addr[7:2]];
      icnt       = 0;
    end else begin
      imem_ready = 1'b0;
      icnt++;
    end
  end

  // Data memory: every cycle of a request is compared with the head of the expected-access queue.
  always begin
    @(negedge clock); #1;
    if (!reset || !dmem_req) begin
      dmem_ready = 1'b0;
      dcnt       = 0;
    end else begin
      chk1("dmem_access_expected", dq.size() != 0, 1'b1);
      if (dq.size() != 0) begin
        dd = dq[0];
        chk1("dmem_we", dmem_we, dd.we);
        chk("dmem_addr", dmem_addr, dd.addr);
        if (dd.we) chk("dmem_wdata", dmem_wdata, dd.wdata);
      end
      if (dcnt >= dmem_wait) begin
        dmem_ready = 1'b1;
        if (dmem_we) dmem[dmem_addr[5:2]] = dmem_wdata;
        dmem_rdata = dmem[dmem_addr[5:2]];
        if (dq.size() != 0) dd = dq.pop_front();
        dcnt = 0;
      end else begin
        dmem_ready = 1'b0;
        dcnt++;
      end
    end
  end

  // Retire monitor: PC of the committing instruction and cycles since the previous commit.
  always begin
    @(negedge clock); #3;
    if (!reset) begin
      cyc = 0;
    end else begin
      cyc++;
      if (retire) begin
        chk1("retire_expected", sq.size() != 0, 1'b1);
        if (sq.size() != 0) begin
          rm = sq.pop_front();
          chk("retire_pc", pc_out, rm.pc);
          chk("retire_latency", 32'(cyc), 32'(rm.lat));
        end
        cyc = 0;
      end
    end
  end

  task automatic release_reset();
    @(posedge clock); #2;
    reset = 1'b1;
  endtask

  task automatic enter_reset();
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
  endtask

  task automatic wait_halt(input int maxc);
    int n;
    n = 0;
    while (n < maxc && !halted) begin
      @(posedge clock); #2;
      n++;
    end
    chk1("halt_reached", halted, 1'b1);
  endtask

  task automatic chk_reg(input int r, input logic [31:0] exp);
    dbg_sel = 5'(r);
    #1;
    chk($sformatf("reg_x%0d", r), dbg_data, exp);
  endtask

  task automatic chk_quiet_halt(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock); #2;
      chk1("no_fetch_in_halt", imem_req, 1'b0);
      chk1("no_retire_in_halt", retire, 1'b0);
    end
  endtask

  initial begin
    int n;
    dbg_sel    = 5'd0;
    imem_wait  = 0;
    dmem_wait  = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    imem_rdata = 32'h0;
    dmem_rdata = 32'h0;
    clear_mem();
    repeat (2) @(posedge clock);
    #2;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk1("rst_retire", retire, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk("rst_pc", pc_out, 32'h0);

    // ALU program, zero wait states: 4 cycles per instruction, ends on ecall.
    imem[0]  = enc_i(5, 0, 3'b000, 1, OP_I);
    imem[1]  = enc_i(-3, 0, 3'b000, 2, OP_I);
    imem[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);
    imem[3]  = enc_r(7'h20, 1, 0, 3'b000, 4);
    imem[4]  = enc_r(7'h00, 1, 4, 3'b010, 5);
    imem[5]  = enc_i(7, 0, 3'b000, 0, OP_I);
    imem[6]  = enc_i(240, 1, 3'b100, 7, OP_I);
    imem[7]  = enc_r(7'h00, 1, 1, 3'b001, 8);
    imem[8]  = enc_r(7'h00, 1, 4, 3'b101, 9);
    imem[9]  = enc_r(7'h00, 7, 4, 3'b111, 10);
    imem[10] = enc_i(0, 4, 3'b010, 12, OP_I);
    imem[11] = enc_i(15, 7, 3'b111, 14, OP_I);
    imem[12] = enc_r(7'h00, 1, 8, 3'b110, 11);
    imem[13] = ECALL;
    for (int i = 0; i < 13; i++) exp_ret(32'(4 * i), 4);
    release_reset();
    wait_halt(200);
    chk1("a_illegal", illegal, 1'b0);
    chk("a_pc", pc_out, 32'h34);
    chk_reg(1, 32'd5);
    chk_reg(2, 32'hFFFF_FFFD);
    chk_reg(3, 32'd2);
    chk_reg(4, 32'hFFFF_FFFB);
    chk_reg(5, 32'd1);
    chk_reg(0, 32'd0);
    chk_reg(7, 32'h0000_00F5);
    chk_reg(8, 32'h0000_00A0);
    chk_reg(9, 32'h07FF_FFFF);
    chk_reg(10, 32'h0000_00F1);
    chk_reg(11, 32'h0000_00A5);
    chk_reg(12, 32'd1);
    chk_reg(14, 32'd5);
    chk_quiet_halt(3);
    chk("a_retires_left", 32'(sq.size()), 32'd0);
    enter_reset();

    // Store then load with three dmem wait cycles.
    clear_mem();
    dmem_wait = 3;
    imem[0] = enc_i(5, 0, 3'b000, 1, OP_I);
    imem[1] = enc_s(8, 1, 0);
    imem[2] = enc_i(8, 0, 3'b010, 6, OP_LW);
    imem[3] = ECALL;
    exp_ret(32'h0, 4);
    exp_ret(32'h4, 7);
    exp_ret(32'h8, 8);
    exp_dm(1'b1, 32'h8, 32'h5);
    exp_dm(1'b0, 32'h8, 32'h0);
    release_reset();
    wait_halt(200);
    chk_reg(6, 32'd5);
    chk("b_dmem_word", dmem[2], 32'd5);
    chk("b_pc", pc_out, 32'hC);
    chk("b_retires_left", 32'(sq.size()), 32'd0);
    chk("b_dmem_left", 32'(dq.size()), 32'd0);
    enter_reset();

    // Taken branches: 0x00 -> 0x10, then beq -8 at 0x10 -> 0x08 (ecall).
    clear_mem();
    dmem_wait = 0;
    imem[0] = enc_b(16, 0, 0, 3'b000);
    imem[4] = enc_b(-8, 0, 0, 3'b000);
    imem[2] = ECALL;
    exp_ret(32'h00, 3);
    exp_ret(32'h10, 3);
    release_reset();
    wait_halt(100);
    chk("c_pc", pc_out, 32'h08);
    chk("c_imem_addr", imem_addr, 32'h08);
    chk1("c_illegal", illegal, 1'b0);
    chk("c_retires_left", 32'(sq.size()), 32'd0);
    enter_reset();

    // Fetch wait states, untaken bne at 0x10, then an unsupported opcode.
    clear_mem();
    imem_wait = 2;
    for (int i = 0; i < 4; i++) imem[i] = NOP;
    imem[4] = enc_b(-8, 0, 0, 3'b001);
    imem[5] = 32'h0000_007F;
    for (int i = 0; i < 4; i++) exp_ret(32'(4 * i), 6);
    exp_ret(32'h10, 5);
    release_reset();
    wait_halt(200);
    chk1("d_illegal", illegal, 1'b1);
    chk("d_pc", pc_out, 32'h14);
    chk_quiet_halt(4);
    chk("d_retires_left", 32'(sq.size()), 32'd0);
    enter_reset();
    chk1("d_illegal_cleared", illegal, 1'b0);
    chk1("d_halt_cleared", halted, 1'b0);

    // Reset while a store is waiting in MEM, then rerun the same program.
    clear_mem();
    imem_wait = 0;
    dmem_wait = 20;
    imem[0] = enc_i(5, 0, 3'b000, 1, OP_I);
    imem[1] = enc_s(8, 1, 0);
    imem[2] = ECALL;
    exp_ret(32'h0, 4);
    exp_dm(1'b1, 32'h8, 32'h5);
    release_reset();
    n = 0;
    while (n < 30 && !dmem_req) begin
      @(posedge clock); #2;
      n++;
    end
    chk1("e_dmem_req_seen", dmem_req, 1'b1);
    @(posedge clock);
    enter_reset();
    chk1("e_dmem_req_dropped", dmem_req, 1'b0);
    chk1("e_imem_req_in_reset", imem_req, 1'b0);
    chk("e_pc_reset", pc_out, 32'h0);
    chk_reg(1, 32'd0);
    chk("e_retires_left", 32'(sq.size()), 32'd0);
    dq.delete();
    dmem_wait = 0;
    exp_ret(32'h0, 4);
    exp_ret(32'h4, 4);
    exp_dm(1'b1, 32'h8, 32'h5);
    repeat (2) @(posedge clock);
    release_reset();
    wait_halt(100);
    chk_reg(1, 32'd5);
    chk("e_dmem_word", dmem[2], 32'd5);
    chk("e_pc", pc_out, 32'h8);
    chk("e_retires_left_2", 32'(sq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
